// File: rtl/leaf_stream_packetizer.sv
// ---------------------------------------------------------------------------
// leaf_stream_packetizer
//
// Transmit-side endpoint of a leaf's BFT port. Each word the kernel presents
// on din_user/vld_user is wrapped as a 49-bit data packet and sent to
// dest_leaf/dest_port. The packet carries the receiver's next write address.
// A credit counter mirrors the free space in the remote receiver buffer.
// That buffer holds 2^NUM_BRAM_ADDR_BITS words. Freespace packets snooped
// from the incoming BFT stream refill the counter. A resend pulse replays
// the last data packet without consuming credit.
//
// Packet: [48] valid, [47:44] leaf, [43:40] port, [39] credit flag,
//         [38:32] addr, [31:0] payload
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dest_leaf, dest_port       destination of outgoing data (quasi-static)
//   din_user, vld_user         kernel output word and its valid
//   ack_user                   combinational accept strobe back to kernel
//   din_leaf_bft2interface     incoming BFT packets, snooped for credit
//   dout_leaf_interface2bft    outgoing BFT packet, registered
//   resend                     replay the last data packet
//   credit_cnt                 current credit, for debug
// ---------------------------------------------------------------------------
module leaf_stream_packetizer #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 4,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int OUT_PORT           = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]      dest_port,
  input  logic [PAYLOAD_BITS-1:0]       din_user,
  input  logic                          vld_user,
  output logic                          ack_user,
  input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
  input  logic                          resend,
  output logic [NUM_BRAM_ADDR_BITS:0]   credit_cnt
);

  localparam int CREDIT_W = NUM_BRAM_ADDR_BITS + 1;
  localparam int SUM_W    = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(1) << NUM_BRAM_ADDR_BITS;

  // Bit positions inside a packet
  localparam int FLAG_BIT = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int PORT_LSB = FLAG_BIT + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XMIT   = 2'd1,
    REPLAY = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [PACKET_BITS-1:0]     dout_q, dout_d;
  logic [PACKET_BITS-1:0]     last_pkt_q, last_pkt_d;
  logic                       have_last_q, have_last_d;
  logic [NUM_ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [CREDIT_W-1:0]        credit_q, credit_d;

  logic                       credit_avail;
  logic                       replay_req;
  logic                       credit_pkt;
  logic [7:0]                 credit_inc;
  logic [SUM_W-1:0]           credit_sum;
  logic [PACKET_BITS-1:0]     data_pkt;

  // While reset is high the credit is treated as zero, so nothing is acked
  // in the reset cycle even though credit_q may still hold an old value.
  assign credit_avail = !reset && (credit_q != '0);
  assign replay_req   = resend && have_last_q;
  assign ack_user     = vld_user && credit_avail && !replay_req;

  assign credit_pkt = din_leaf_bft2interface[PACKET_BITS-1]
                   && din_leaf_bft2interface[FLAG_BIT]
                   && (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS]
                       == NUM_PORT_BITS'(OUT_PORT));
  assign credit_inc = credit_pkt ? din_leaf_bft2interface[7:0] : 8'd0;

  // An accept needs credit >= 1, so the sum never underflows. It can exceed
  // the buffer size when a large return arrives, hence the saturation.
  assign credit_sum = SUM_W'(credit_q) + SUM_W'(credit_inc) - SUM_W'(ack_user);

  assign data_pkt = {1'b1, dest_leaf, dest_port, 1'b0, wr_addr_q, din_user};

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = IDLE;
    dout_d      = '0;
    last_pkt_d  = last_pkt_q;
    have_last_d = have_last_q;
    wr_addr_d   = wr_addr_q;

    if (replay_req) begin
      state_d = REPLAY;
    end else if (vld_user && credit_avail) begin
      state_d = XMIT;
    end

    unique case (state_d)
      XMIT: begin
        dout_d      = data_pkt;
        last_pkt_d  = data_pkt;
        have_last_d = 1'b1;
        wr_addr_d   = wr_addr_q + 1'b1;  // wraps naturally at 2^NUM_ADDR_BITS
      end
      REPLAY:  dout_d = last_pkt_q;
      default: dout_d = '0;
    endcase

    credit_d = (credit_sum > SUM_W'(CREDIT_MAX)) ? CREDIT_MAX
                                                 : credit_sum[CREDIT_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dout_q      <= '0;
      last_pkt_q  <= '0;
      have_last_q <= 1'b0;
      wr_addr_q   <= '0;
      credit_q    <= CREDIT_MAX;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      last_pkt_q  <= last_pkt_d;
      have_last_q <= have_last_d;
      wr_addr_q   <= wr_addr_d;
      credit_q    <= credit_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign credit_cnt              = credit_q;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// ---------------------------------------------------------------------------
// tb_leaf_stream_packetizer
//
// Directed scenarios followed by a randomized run. The expected values come
// from a transaction-level model of the remote buffer's view: a credit count,
// the next receiver address and the last packet sent. The model is advanced
// once per clock.
// ---------------------------------------------------------------------------
module tb_leaf_stream_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dest_leaf, dest_port;
  logic [31:0] din_user;
  logic        vld_user, ack_user, resend;
  logic [48:0] din_leaf_bft2interface, dout_leaf_interface2bft;
  logic [7:0]  credit_cnt;

  leaf_stream_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .dest_leaf               (dest_leaf),
    .dest_port               (dest_port),
    .din_user                (din_user),
    .vld_user                (vld_user),
    .ack_user                (ack_user),
    .din_leaf_bft2interface  (din_leaf_bft2interface),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .resend                  (resend),
    .credit_cnt              (credit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state
  int          m_credit;
  int          m_addr;
  logic [48:0] m_last;
  bit          m_have_last;
  logic [48:0] m_dout;

  function automatic logic [48:0] credit_msg(input logic [3:0] port, input bit flag,
                                             input logic [7:0] amount);
    logic [48:0] p;
    p = {1'b1, 4'h0, port, flag, 7'h0, 24'h0, amount};
    return p;
  endfunction

  task automatic model_reset();
    m_credit = 128; m_addr = 0; m_last = '0; m_have_last = 0; m_dout = '0;
  endtask

  // One reset cycle with vld held high: nothing may be accepted.
  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset = 1'b1; vld_user = 1'b1; resend = 1'b0; din_leaf_bft2interface = '0;
      din_user = $urandom;
      #1 check("rst_ack", 64'(ack_user), 64'd0);
      @(posedge clk); #1;
      check("rst_dout",   64'(dout_leaf_interface2bft), 64'd0);
      check("rst_credit", 64'(credit_cnt), 64'd128);
    end
    @(negedge clk);
    reset = 1'b0; vld_user = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, check ack against the model, advance the model, then
  // check the registered output and the credit after the edge.
  task automatic cycle(input bit vld, input logic [31:0] data, input bit rs,
                       input logic [48:0] bft, output bit acked);
    bit          exp_ack, is_credit;
    int          inc;
    @(negedge clk);
    vld_user = vld; din_user = data; resend = rs; din_leaf_bft2interface = bft;
    #1;
    exp_ack = vld && (m_credit > 0) && !(rs && m_have_last);
    check("ack", 64'(ack_user), 64'(exp_ack));
    acked = ack_user;

    is_credit = bft[48] && bft[39] && (bft[43:40] == 4'd1);
    inc = is_credit ? int'(bft[7:0]) : 0;
    if (rs && m_have_last) begin
      m_dout = m_last;
    end else if (exp_ack) begin
      m_dout = {1'b1, dest_leaf, dest_port, 1'b0, 7'(m_addr), data};
      m_last = m_dout;
      m_have_last = 1;
      m_addr = (m_addr + 1) % 128;
    end else begin
      m_dout = '0;
    end
    m_credit = m_credit - (exp_ack ? 1 : 0) + inc;
    if (m_credit > 128) m_credit = 128;

    @(posedge clk); #1;
    check("dout",   64'(dout_leaf_interface2bft), 64'(m_dout));
    check("credit", 64'(credit_cnt), 64'(m_credit));
  endtask

  bit          a;
  int          acks;
  logic [48:0] exp_pkt;

  initial begin
    reset = 1'b1; vld_user = 1'b0; resend = 1'b0; din_user = '0;
    din_leaf_bft2interface = '0; dest_leaf = 4'h5; dest_port = 4'h2;
    model_reset();

    // Reset with vld high, then a single word
    do_reset(2);
    cycle(1, 32'hDEADBEEF, 0, '0, a);
    check("single_ack", 64'(a), 64'd1);
    exp_pkt = {1'b1, 4'h5, 4'h2, 1'b0, 7'd0, 32'hDEADBEEF};
    check("single_pkt", 64'(dout_leaf_interface2bft), 64'(exp_pkt));
    cycle(0, '0, 0, '0, a);
    check("single_gap", 64'(dout_leaf_interface2bft), 64'd0);
    check("single_credit", 64'(credit_cnt), 64'd127);

    // Credit exhaustion, then a credit return of 64
    do_reset(1);
    acks = 0;
    for (int i = 0; i < 140; i++) begin
      cycle(1, 32'(i), 0, '0, a);
      acks += int'(a);
    end
    check("exhaust_acks", 64'(acks), 64'd128);
    check("exhaust_credit", 64'(credit_cnt), 64'd0);
    cycle(1, 32'hA0, 0, credit_msg(4'd1, 1, 8'd64), a);
    check("credit_lag_ack", 64'(a), 64'd0);
    cycle(1, 32'hA1, 0, '0, a);
    check("resume_ack", 64'(a), 64'd1);
    check("resume_addr", 64'(dout_leaf_interface2bft[38:32]), 64'd0);
    check("resume_credit", 64'(credit_cnt), 64'd63);

    // Simultaneous accept + credit, ignored credit packets, saturation
    do_reset(1);
    for (int i = 0; i < 118; i++) cycle(1, $urandom, 0, '0, a);
    check("credit10", 64'(credit_cnt), 64'd10);
    cycle(1, 32'h55, 0, credit_msg(4'd1, 1, 8'd5), a);
    check("credit14", 64'(credit_cnt), 64'd14);
    cycle(0, '0, 0, credit_msg(4'd3, 1, 8'd5), a);
    cycle(0, '0, 0, credit_msg(4'd1, 0, 8'd5), a);
    check("credit_ignored", 64'(credit_cnt), 64'd14);
    cycle(0, '0, 0, credit_msg(4'd1, 1, 8'd86), a);
    check("credit100", 64'(credit_cnt), 64'd100);
    cycle(0, '0, 0, credit_msg(4'd1, 1, 8'd200), a);
    check("credit_sat", 64'(credit_cnt), 64'd128);

    // Resend replays the previous packet and blocks the concurrent word
    do_reset(1);
    cycle(1, 32'h1, 0, '0, a);
    cycle(1, 32'h2, 0, '0, a);
    cycle(1, 32'h3, 1, '0, a);
    check("resend_ack", 64'(a), 64'd0);
    exp_pkt = {1'b1, 4'h5, 4'h2, 1'b0, 7'd1, 32'h2};
    check("resend_pkt", 64'(dout_leaf_interface2bft), 64'(exp_pkt));
    cycle(1, 32'h3, 0, '0, a);
    check("after_resend_addr", 64'(dout_leaf_interface2bft[38:32]), 64'd2);
    check("after_resend_credit", 64'(credit_cnt), 64'd125);

    // Resend with nothing sent yet is ignored
    do_reset(1);
    cycle(0, '0, 1, '0, a);
    check("resend_empty", 64'(dout_leaf_interface2bft), 64'd0);
    cycle(1, 32'hAA, 1, '0, a);
    check("resend_empty_ack", 64'(a), 64'd1);

    // Randomized traffic
    dest_leaf = 4'($urandom); dest_port = 4'($urandom);
    for (int i = 0; i < 3000; i++) begin
      logic [48:0] bft;
      bit vld, rs;
      if ($urandom_range(0, 399) == 0) do_reset(1);
      vld = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       bft = credit_msg(4'd1, 1, 8'($urandom_range(0, 40)));
        1:       bft = credit_msg(4'($urandom), 1'($urandom), 8'($urandom));
        2:       bft = 49'($urandom) | (49'($urandom) << 32);
        default: bft = '0;
      endcase
      cycle(vld, $urandom, rs, bft, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
